// File: rtl/hamming_link_ctrl.sv
// Drives one encode -> error-inject -> decode round trip through external Hamming(7,4) engines.
// Captures the codewords and decoded result, and keeps saturating transaction and error counters.
module hamming_link_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       start_i,
    input  logic [3:0] message_i,
    input  logic       error_inject_i,
    input  logic [2:0] error_pos1_i,
    input  logic [2:0] error_pos2_i,
    input  logic       enc_ready_i,
    output logic       enc_start_o,
    output logic [3:0] enc_msg_o,
    input  logic       enc_valid_i,
    input  logic [6:0] enc_code_i,
    output logic       dec_start_o,
    output logic [6:0] dec_code_o,
    input  logic       dec_valid_i,
    input  logic [3:0] dec_msg_i,
    input  logic       dec_err_det_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [6:0] tx_code_o,
    output logic [6:0] rx_code_o,
    output logic [3:0] result_msg_o,
    output logic       err_det_o,
    output logic       msg_ok_o,
    output logic       timeout_o,
    output logic [7:0] txn_count_o,
    output logic [7:0] err_count_o
);

    typedef enum logic [2:0] {
        IDLE, ENC_REQ, ENC_WAIT, INJECT, DEC_REQ, DEC_WAIT, REPORT
    } state_t;

    // The counter sits at TIMEOUT-1 during the last permitted wait cycle.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [3:0] msg_q;
    logic       inject_q;
    logic [2:0] pos1_q;
    logic [2:0] pos2_q;
    logic [7:0] wait_q;
    logic       enc_start_q;
    logic       dec_start_q;
    logic       busy_q;
    logic       done_q;
    logic [6:0] tx_q;
    logic [6:0] rx_q;
    logic [3:0] result_q;
    logic       err_det_q;
    logic       msg_ok_q;
    logic       timeout_q;
    logic [7:0] txn_q;
    logic [7:0] errc_q;

    logic [6:0] mask_d;
    logic       in_wait_d;
    logic       handshake_d;
    logic       abort_d;
    logic       finish_d;
    logic       ok_d;

    // Position 7 selects no bit, so two equal positions collapse to a single flip.
    function automatic logic [6:0] pos_bit(input logic [2:0] pos);
        return (pos == 3'd7) ? 7'd0 : (7'd1 << pos);
    endfunction

    always_comb begin
        mask_d = '0;
        if (inject_q) begin
            mask_d = pos_bit(pos1_q) | pos_bit(pos2_q);
        end
        in_wait_d   = (state_q == ENC_REQ) || (state_q == ENC_WAIT) || (state_q == DEC_WAIT);
        handshake_d = ((state_q == ENC_REQ)  && enc_ready_i) ||
                      ((state_q == ENC_WAIT) && enc_valid_i) ||
                      ((state_q == DEC_WAIT) && dec_valid_i);
        abort_d     = in_wait_d && !handshake_d && (wait_q == WAIT_LIMIT);
        finish_d    = abort_d || ((state_q == DEC_WAIT) && dec_valid_i);
        ok_d        = !abort_d && (dec_msg_i == msg_q);
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            msg_q       <= '0;
            inject_q    <= 1'b0;
            pos1_q      <= '0;
            pos2_q      <= '0;
            wait_q      <= '0;
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            result_q    <= '0;
            err_det_q   <= 1'b0;
            msg_ok_q    <= 1'b0;
            timeout_q   <= 1'b0;
            txn_q       <= '0;
            errc_q      <= '0;
        end else begin
            done_q      <= 1'b0;
            dec_start_q <= 1'b0;
            if (in_wait_d) begin
                wait_q <= handshake_d ? 8'd0 : wait_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        msg_q       <= message_i;
                        inject_q    <= error_inject_i;
                        pos1_q      <= error_pos1_i;
                        pos2_q      <= error_pos2_i;
                        timeout_q   <= 1'b0;
                        msg_ok_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        enc_start_q <= 1'b1;
                        wait_q      <= '0;
                        state_q     <= ENC_REQ;
                    end
                end
                ENC_REQ: begin
                    if (enc_ready_i) begin
                        enc_start_q <= 1'b0;
                        state_q     <= ENC_WAIT;
                    end
                end
                ENC_WAIT: begin
                    if (enc_valid_i) begin
                        tx_q    <= enc_code_i;
                        state_q <= INJECT;
                    end
                end
                INJECT: begin
                    rx_q        <= tx_q ^ mask_d;
                    dec_start_q <= 1'b1;
                    state_q     <= DEC_REQ;
                end
                DEC_REQ: begin
                    wait_q  <= '0;
                    state_q <= DEC_WAIT;
                end
                DEC_WAIT: begin
                    if (dec_valid_i) begin
                        result_q  <= dec_msg_i;
                        err_det_q <= dec_err_det_i;
                        state_q   <= REPORT;
                    end
                end
                REPORT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // An expired wait overrides whatever the state above chose.
            if (abort_d) begin
                enc_start_q <= 1'b0;
                timeout_q   <= 1'b1;
                state_q     <= REPORT;
            end
            if (finish_d) begin
                done_q   <= 1'b1;
                msg_ok_q <= ok_d;
                if (txn_q != 8'hFF) begin
                    txn_q <= txn_q + 8'd1;
                end
                if (!ok_d && (errc_q != 8'hFF)) begin
                    errc_q <= errc_q + 8'd1;
                end
            end
        end
    end

    assign enc_start_o  = enc_start_q;
    assign enc_msg_o    = msg_q;
    assign dec_start_o  = dec_start_q;
    assign dec_code_o   = rx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign tx_code_o    = tx_q;
    assign rx_code_o    = rx_q;
    assign result_msg_o = result_q;
    assign err_det_o    = err_det_q;
    assign msg_ok_o     = msg_ok_q;
    assign timeout_o    = timeout_q;
    assign txn_count_o  = txn_q;
    assign err_count_o  = errc_q;

endmodule
